// File: rtl/rob_flush_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rob_flush_ctrl_pkg : shared types for the misprediction flush sequencer
// Revision 1.0 - initial release
// ============================================================================
package rob_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    FLUSH_IDLE     = 2'd0,
    FLUSH_DRAIN    = 2'd1,
    FLUSH_FLUSH    = 2'd2,
    FLUSH_REDIRECT = 2'd3
  } flush_state_t;

  // Holds FLUSH_CYCLES, whose legal range tops out at 15.
  localparam int unsigned FLUSH_CNT_WIDTH = 4;

endpackage : rob_flush_ctrl_pkg
`default_nettype wire

// File: rtl/store_pending_counter.sv
`default_nettype none
// ============================================================================
// store_pending_counter : saturating up/down counter with sticky error flag
// Revision 1.0 - initial release
// ============================================================================
module store_pending_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_err
);

  localparam logic [WIDTH-1:0] c_count_max = '1;

  logic [WIDTH-1:0] r_count;
  logic             r_err;
  logic [WIDTH-1:0] w_next;
  logic             w_err;

  // Simultaneous increment and decrement cancel and can never flag an error.
  always_comb begin
    w_next = r_count;
    w_err  = 1'b0;
    if (i_en) begin
      if (i_inc && !i_dec) begin
        if (r_count == c_count_max) w_err = 1'b1;
        else                        w_next = r_count + 1'b1;
      end else if (i_dec && !i_inc) begin
        if (r_count == '0) w_err = 1'b1;
        else               w_next = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_en) begin
      r_count <= w_next;
      r_err   <= r_err | w_err;
    end
  end

  assign o_count = r_count;
  assign o_next  = w_next;
  assign o_err   = r_err;

endmodule : store_pending_counter
`default_nettype wire

// File: rtl/rob_flush_ctrl.sv
`default_nettype none
// ============================================================================
// rob_flush_ctrl : stalls commit, drains stores, flushes the bus, redirects fetch
// Revision 1.0 - initial release
// ============================================================================
module rob_flush_ctrl
  import rob_flush_ctrl_pkg::*;
#(
  parameter int REG_WIDTH       = 32,
  parameter int STORE_CNT_WIDTH = 5,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       commit_valid_in,
  input  logic                       commit_mispredict_in,
  input  logic                       commit_store_in,
  input  logic [REG_WIDTH-1:0]       commit_next_pc_in,
  input  logic                       store_done_in,
  output logic                       commit_stall_out,
  output logic                       flush_out,
  output logic                       redirect_valid_out,
  output logic [REG_WIDTH-1:0]       redirect_pc_out,
  output logic [STORE_CNT_WIDTH-1:0] store_pending_out,
  output logic                       cnt_err_out
);

  localparam logic [FLUSH_CNT_WIDTH-1:0] c_flush_load = FLUSH_CNT_WIDTH'(FLUSH_CYCLES);

  flush_state_t                r_state;
  flush_state_t                w_state_next;
  logic [FLUSH_CNT_WIDTH-1:0]  r_flush_cnt;
  logic [FLUSH_CNT_WIDTH-1:0]  w_flush_cnt_next;
  logic [REG_WIDTH-1:0]        r_target;
  logic                        r_stall;
  logic                        r_flush;
  logic                        r_redirect;
  logic                        w_accept;
  logic                        w_latch;
  logic [STORE_CNT_WIDTH-1:0]  w_cnt_next;

  assign w_accept = rdy_in && commit_valid_in && (r_state == FLUSH_IDLE);

  store_pending_counter #(
    .WIDTH (STORE_CNT_WIDTH)
  ) u_store_cnt (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .i_en    (rdy_in),
    .i_inc   (w_accept && commit_store_in),
    .i_dec   (store_done_in),
    .o_count (store_pending_out),
    .o_next  (w_cnt_next),
    .o_err   (cnt_err_out)
  );

  // Decisions use the post-edge store count so draining adds no extra bubble.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_latch          = 1'b0;
    case (r_state)
      FLUSH_IDLE: begin
        if (w_accept && commit_mispredict_in) begin
          w_latch = 1'b1;
          if (w_cnt_next != '0) begin
            w_state_next = FLUSH_DRAIN;
          end else begin
            w_state_next     = FLUSH_FLUSH;
            w_flush_cnt_next = c_flush_load;
          end
        end
      end
      FLUSH_DRAIN: begin
        if (w_cnt_next == '0) begin
          w_state_next     = FLUSH_FLUSH;
          w_flush_cnt_next = c_flush_load;
        end
      end
      FLUSH_FLUSH: begin
        w_flush_cnt_next = r_flush_cnt - 1'b1;
        if (r_flush_cnt == FLUSH_CNT_WIDTH'(1)) w_state_next = FLUSH_REDIRECT;
      end
      FLUSH_REDIRECT: begin
        w_state_next = FLUSH_IDLE;
      end
      default: begin
        w_state_next = FLUSH_IDLE;
      end
    endcase
  end

  // Outputs are flopped from the next state so they line up with r_state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= FLUSH_IDLE;
      r_flush_cnt <= '0;
      r_target    <= '0;
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_redirect  <= 1'b0;
    end else if (rdy_in) begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      if (w_latch) r_target <= commit_next_pc_in;
      r_stall     <= (w_state_next != FLUSH_IDLE);
      r_flush     <= (w_state_next == FLUSH_FLUSH);
      r_redirect  <= (w_state_next == FLUSH_REDIRECT);
    end
  end

  assign commit_stall_out   = r_stall;
  assign flush_out          = r_flush;
  assign redirect_valid_out = r_redirect;
  assign redirect_pc_out    = r_target;

endmodule : rob_flush_ctrl
`default_nettype wire

// File: doc/rob_flush_ctrl.md
# rob_flush_ctrl

Sequences the misprediction flush on the reorder-buffer commit path. It sits between the reorder buffer and the commit fan-out bus, and tracks committed stores not yet written to memory. On a mispredicted branch commit it stalls further commits and waits for those stores to drain. It then drives a multi-cycle flush into the bus reset input and finally issues a one-cycle fetch redirect.

## Interface
Parameters:
- `REG_WIDTH`, 32, width of PC values.
- `STORE_CNT_WIDTH`, 5, width of the outstanding-committed-store counter.
- `FLUSH_CYCLES`, 2, cycles `flush_out` stays high; legal range 1..15.

Ports:
- `clk_in` input 1: the single clock; all state updates on its rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: global ready; when low, all state and counters hold and outputs keep their values.
- `commit_valid_in` input 1: reorder buffer commits one entry this cycle.
- `commit_mispredict_in` input 1: the committing entry is a mispredicted branch.
- `commit_store_in` input 1: the committing entry is a store handed to the load/store buffer.
- `commit_next_pc_in` input `REG_WIDTH`: correct next PC for the committing branch.
- `store_done_in` input 1: load/store buffer finished one committed store to memory.
- `commit_stall_out` output 1: reorder buffer must not commit.
- `flush_out` output 1: reset to the commit fan-out bus, which feeds issuer, reservation station, reorder buffer, register file and load/store buffer.
- `redirect_valid_out` output 1: fetcher redirect strobe.
- `redirect_pc_out` output `REG_WIDTH`: redirect target.
- `store_pending_out` output `STORE_CNT_WIDTH`: current outstanding committed-store count.
- `cnt_err_out` output 1: sticky flag for counter overflow or underflow.

## Operation
- **States:** IDLE, DRAIN, FLUSH, REDIRECT; 2-bit encoding.
- **Accepted commit:** `commit_valid_in` and `rdy_in` high and state IDLE.
- **Commits outside IDLE:** ignored, with no counter update and no state change.
- **Store counter increment:** +1 on an accepted commit with `commit_store_in`.
- **Store counter decrement:** −1 on `store_done_in`.
- **Both in one cycle:** count unchanged.
- **Increment at maximum:** saturates and sets `cnt_err_out`.
- **Decrement at 0:** stays 0 and sets `cnt_err_out`.
- **IDLE:**
  - Accepted commit with `commit_mispredict_in`: latch `commit_next_pc_in` into the target register.
  - Go to DRAIN if the next count is nonzero, else FLUSH.
  - FLUSH entry loads the flush counter with `FLUSH_CYCLES`.
- **DRAIN:** when the next count is 0, go to FLUSH and load the flush counter.
- **FLUSH:**
  - `flush_out` = 1.
  - Flush counter decrements each cycle; at 1, go to REDIRECT.
  - The store counter is not cleared by the flush.
- **REDIRECT:** `redirect_valid_out` = 1 for one cycle, then IDLE.
- **Stall:** `commit_stall_out` = 1 in every state except IDLE.
- **Outputs are registered:**
  - `flush_out` = (state == FLUSH).
  - `redirect_valid_out` = (state == REDIRECT).
  - `redirect_pc_out` = latched target; it holds after REDIRECT until the next mispredict.
- **Mispredict and store together:** the store is counted and the mispredict path is taken.
- **Reset (any time, including mid-flush):**
  - State IDLE; counters 0.
  - All outputs 0, including `redirect_pc_out` and `cnt_err_out`.
  - Any flush in progress is abandoned.

## Timing
- Mispredict accepted in cycle T with count 0 and no store:
  - `commit_stall_out` high T+1..T+`FLUSH_CYCLES`+1.
  - `flush_out` high T+1..T+`FLUSH_CYCLES`.
  - `redirect_valid_out` high at T+`FLUSH_CYCLES`+1.
  - Next commit acceptable at T+`FLUSH_CYCLES`+2.
- With pending stores, FLUSH starts the cycle after the edge at which the count reaches 0.
- The DRAIN phase adds no extra bubble beyond the waiting itself.
- `rdy_in` low:
  - Every register holds, including the flush counter, so the `flush_out` pulse stretches.
  - `store_done_in` and commits are ignored.
- `store_pending_out` reflects the count after the previous edge.

## Structure
- Add to the shared `config.v`:
  - `FLUSH_STATE_TYPE` [1:0].
  - The state macros `FLUSH_IDLE`, `FLUSH_DRAIN`, `FLUSH_FLUSH`, `FLUSH_REDIRECT`.
  - `STORE_CNT_TYPE`.
- Reuse `REG_TYPE` for PCs.
- One sub-module, `store_pending_counter`: up/down saturating counter with an error flag, parameterized by width.
- The FSM and target latch stay in the top module.
- `flush_out` drives the bus's `reset_from_ro_buffer`. `redirect_pc_out` supersedes the bus's next-PC path for fetch redirect.

## Test plan
- Reset low mid-FLUSH (`flush_out`=1, count 3) -> next cycle all outputs 0, state IDLE, count 0; IDLE 1 cycle after release.
- Mispredict with `commit_next_pc_in`=0x00001234, count 0, `FLUSH_CYCLES`=2 at T -> `flush_out` high T+1,T+2; `redirect_valid_out`=1 with PC 0x00001234 at T+3; stall high T+1..T+3.
- 3 store commits, then mispredict, then `store_done_in` at T+2,T+4,T+6 -> DRAIN until count 0 at T+7; `flush_out` high T+7,T+8; redirect at T+9.
- `store_done_in` and a store commit in the same cycle with count 2 -> count stays 2; `store_done_in` at count 0 -> stays 0 and `cnt_err_out`=1 sticky.
- `rdy_in` low for 3 cycles during FLUSH with `FLUSH_CYCLES`=2 -> `flush_out` high 5 cycles total; redirect fires once, PC unchanged.
- Commit with `commit_valid_in` during DRAIN -> ignored, count unchanged; `commit_stall_out` stays 1.
